// File: rtl/dht11_sensor_emulator.sv
// DHT11 single-wire sensor emulator: answers a host start pulse with the 40-bit humidity/temperature frame.
// Latency: the response starts RESP_DELAY_US plus 3 clocks (2-flop sync + state register) after the host releases the line.
// Backpressure: none; the host must follow DHT11 timing, and bus activity during a frame is ignored.
module dht11_sensor_emulator #(
    parameter int CYCLES_PER_US = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int RESP_LOW_US   = 80,
    parameter int RESP_HIGH_US  = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 27,
    parameter int BIT1_HIGH_US  = 70,
    parameter int END_LOW_US    = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    inout  wire        transmission_line,
    output logic       busy,
    output logic       frame_done,
    output logic       start_error
);

    localparam int PRE_W  = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam int US_MAX = (START_MIN_US > 255) ? START_MIN_US : 255;
    localparam int US_W   = $clog2(US_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_MEASURE_START,
        S_WAIT_RELEASE,
        S_RESP_DELAY,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t            state_q;
    logic [PRE_W-1:0]  pre_q;
    logic [US_W-1:0]   us_q;
    logic [39:0]       shift_q;
    logic [5:0]        bit_idx_q;
    logic              drive_low_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              line_prev_q;

    logic              tick;
    logic              line_fall;
    logic              phase_end;
    logic [7:0]        checksum;
    int                phase_len;

    // Open-drain driver: only ever pull low, otherwise float.
    assign transmission_line = drive_low_q ? 1'b0 : 1'bz;

    assign tick      = (pre_q == PRE_W'(CYCLES_PER_US - 1));
    assign line_fall = line_prev_q & ~sync2_q;
    assign checksum  = hum_int + hum_dec + temp_int + temp_dec;

    // Select the length of the current timed phase and flag its last microsecond tick.
    always_comb begin
        phase_len = 1;
        case (state_q)
            S_RESP_DELAY: phase_len = RESP_DELAY_US;
            S_RESP_LOW:   phase_len = RESP_LOW_US;
            S_RESP_HIGH:  phase_len = RESP_HIGH_US;
            S_BIT_LOW:    phase_len = BIT_LOW_US;
            S_BIT_HIGH:   phase_len = shift_q[39] ? BIT1_HIGH_US : BIT0_HIGH_US;
            S_END_LOW:    phase_len = END_LOW_US;
            default:      phase_len = 1;
        endcase
        phase_end = tick && (us_q == US_W'(phase_len - 1));
    end

    // Two-flop synchronizer on the bus plus a delayed copy for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= transmission_line;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    // Protocol FSM; every state change restarts the prescaler and the us-counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            us_q        <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            drive_low_q <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            start_error <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            start_error <= 1'b0;
            pre_q       <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                us_q <= us_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    us_q <= '0;
                    if (line_fall && enable) begin
                        state_q <= S_MEASURE_START;
                        pre_q   <= '0;
                    end
                end

                S_MEASURE_START: begin
                    if (sync2_q) begin
                        start_error <= 1'b1;
                        state_q     <= S_IDLE;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end else if (tick && (us_q == US_W'(START_MIN_US - 1))) begin
                        state_q <= S_WAIT_RELEASE;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end

                S_WAIT_RELEASE: begin
                    us_q <= '0;
                    if (sync2_q) begin
                        shift_q <= {hum_int, hum_dec, temp_int, temp_dec, checksum};
                        busy    <= 1'b1;
                        state_q <= S_RESP_DELAY;
                        pre_q   <= '0;
                    end
                end

                S_RESP_DELAY: begin
                    if (phase_end) begin
                        state_q     <= S_RESP_LOW;
                        drive_low_q <= 1'b1;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end

                S_RESP_LOW: begin
                    if (phase_end) begin
                        state_q     <= S_RESP_HIGH;
                        drive_low_q <= 1'b0;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end

                S_RESP_HIGH: begin
                    if (phase_end) begin
                        state_q     <= S_BIT_LOW;
                        drive_low_q <= 1'b1;
                        bit_idx_q   <= '0;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end

                S_BIT_LOW: begin
                    if (phase_end) begin
                        state_q     <= S_BIT_HIGH;
                        drive_low_q <= 1'b0;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end

                S_BIT_HIGH: begin
                    if (phase_end) begin
                        drive_low_q <= 1'b1;
                        pre_q       <= '0;
                        us_q        <= '0;
                        if (bit_idx_q == 6'd39) begin
                            state_q <= S_END_LOW;
                        end else begin
                            state_q   <= S_BIT_LOW;
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= {shift_q[38:0], 1'b0};
                        end
                    end
                end

                S_END_LOW: begin
                    if (phase_end) begin
                        state_q     <= S_IDLE;
                        drive_low_q <= 1'b0;
                        frame_done  <= 1'b1;
                        busy        <= 1'b0;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    drive_low_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
